vending_machine_multi: RTL and testbench
========================================

// Module: vending_machine_multi
// PURPOSE
//  Parametrised successor to the 3-state vending FSM: credit accumulator, N selectable
//  items, explicit buy/cancel, and serial change return of one unit per cycle.
//  Sits between the coin-acceptor front end and the dispenser/change-hopper drivers.
// PARAMETERS
//  N_ITEMS     4   number of selectable products (>=2)
//  SEL_W       2   width of item select; 2**SEL_W >= N_ITEMS
//  CREDIT_W    6   credit register width, in coin units
//  PRICE       3   price of every item, in units (1 <= PRICE <= MAX_CREDIT)
//  MAX_CREDIT  63  credit ceiling; must be < 2**CREDIT_W
//  STOCK_INIT  8   per-item stock after reset (STOCK_COUNT_EN only)
// PORTS
//  clk          in   1         system clock, rising edge
//  rst          in   1         asynchronous, active-low reset
//  coin         in   2         00 none, 01 = 1 unit, 10 = 2 units, 11 = 5 units
//  sel          in   SEL_W     item select, sampled with buy
//  buy          in   1         purchase request, level-sampled each cycle
//  cancel       in   1         refund the whole credit
//  vend         out  1         1-cycle dispense strobe
//  vend_item    out  SEL_W     item being dispensed, valid while vend=1
//  change_pulse out  1         one unit of change per cycle while high
//  coin_rej     out  1         1-cycle pulse: coin not accepted (return to user)
//  credit       out  CREDIT_W  current credit
//  busy         out  1         high in VEND/CHANGE
//  sold_out     out  1         1-cycle pulse: buy refused, item out of stock (0 without macro)
// BEHAVIOUR
//  - All outputs are registered. With rst=0, every output is 0, state is IDLE, credit is 0.
//    A reset in any state, including mid-CHANGE, discards the remaining credit.
//  - States: IDLE, CREDIT, VEND, CHANGE. Coin value v is 0/1/2/5 per the encoding.
//  - Same-cycle priority in IDLE/CREDIT: cancel > buy > coin. A coin arriving together with
//    an acted-on cancel/buy raises coin_rej and is not credited.
//  - IDLE: coin!=0 -> credit=v, go to CREDIT. Buy and cancel are ignored.
//  - CREDIT, coin only: if credit+v <= MAX_CREDIT, credit+=v; otherwise coin_rej=1 and
//    credit is unchanged. Credit is visible on the cycle after the accepting edge.
//  - CREDIT, buy with credit >= PRICE: latch sel and go to VEND. If credit < PRICE or
//    sel >= N_ITEMS, the buy is ignored and the state stays CREDIT.
//  - CREDIT, cancel: go to CHANGE (credit > 0 always holds in CREDIT).
//  - VEND (1 cycle): vend=1, vend_item=latched sel, credit-=PRICE. Next state is CHANGE if
//    the remainder > 0, else IDLE.
//  - CHANGE: change_pulse=1 and credit-=1 every cycle. Go to IDLE on the cycle credit reaches 0.
//    N units of change give exactly N consecutive pulses.
//  - Any coin in VEND or CHANGE -> coin_rej=1. Buy and cancel are ignored while busy=1.
//  - Credit never wraps; any arithmetic that would exceed MAX_CREDIT is rejected.
// CONFIGURATION
//  STOCK_COUNT_EN defined: per-item stock counters, each $clog2(STOCK_INIT+1) bits wide.
//    Reset loads STOCK_INIT into every counter; each vend decrements the counter of its item.
//    A buy whose item has stock 0 raises a 1-cycle sold_out pulse, stays in CREDIT and
//    keeps the credit.
//  STOCK_COUNT_EN undefined: no counters, stock is unlimited, sold_out is tied to 0.
// TESTING
//  1. Reset; coin 01 x3; buy sel=2 -> vend=1 for 1 cycle, vend_item=2, no change_pulse, IDLE, credit=0.
//  2. Coin 11; buy sel=0 -> vend, then change_pulse for 2 cycles (credit 2 -> 1 -> 0), IDLE.
//  3. Coin 10; cancel -> no vend, 2 change_pulse cycles, credit=0.
//  4. Build credit to 62; coin 11 -> coin_rej, credit stays 62; coin 01 -> credit=63.
//  5. Credit 5; buy+cancel+coin 01 in the same cycle -> refund of 5 pulses, coin_rej=1, no vend.
//     Drop rst mid-refund -> all outputs 0 asynchronously.
//  6. STOCK_COUNT_EN, STOCK_INIT=1: two purchases of item 0 -> first vends; second gives
//     sold_out=1, credit retained, cancel refunds it.

Source files
------------

// File: rtl/vending_machine_multi.sv
`default_nettype none
// ============================================================================
//  Module      : vending_machine_multi
//  Description : Multi-item vending controller. It accumulates coin credit,
//                vends one of N_ITEMS products on buy, and returns change one
//                unit per cycle. It sits between the coin-acceptor front end
//                and the dispenser/change-hopper drivers.
//  Optional    : `define STOCK_COUNT_EN adds per-item stock counters and the
//                sold_out pulse. Without it, stock is unlimited and sold_out
//                is tied to 0.
//  Ports       : clk          - system clock, rising edge
//                rst          - asynchronous reset, active low
//                coin[1:0]    - 00 none, 01 = 1 unit, 10 = 2 units, 11 = 5 units
//                sel          - item select, sampled together with buy
//                buy          - purchase request (level, sampled each cycle)
//                cancel       - refund the whole credit
//                vend         - 1-cycle dispense strobe
//                vend_item    - item being dispensed, valid while vend=1
//                change_pulse - one unit of change per cycle while high
//                coin_rej     - 1-cycle pulse, coin returned to the user
//                credit       - current credit in coin units
//                busy         - high while vending or returning change
//                sold_out     - 1-cycle pulse, buy refused for lack of stock
//  Revision    : 1.0 - initial release
// ============================================================================
module vending_machine_multi #(
    parameter int N_ITEMS    = 4,
    parameter int SEL_W      = 2,
    parameter int CREDIT_W   = 6,
    parameter int PRICE      = 3,
    parameter int MAX_CREDIT = 63,
    parameter int STOCK_INIT = 8
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [1:0]          coin,
    input  logic [SEL_W-1:0]    sel,
    input  logic                buy,
    input  logic                cancel,
    output logic                vend,
    output logic [SEL_W-1:0]    vend_item,
    output logic                change_pulse,
    output logic                coin_rej,
    output logic [CREDIT_W-1:0] credit,
    output logic                busy,
    output logic                sold_out
);

    // Elaboration-time sanity check of the parameter set.
    if (N_ITEMS < 2 || N_ITEMS > (1 << SEL_W) || PRICE < 1 || PRICE > MAX_CREDIT ||
        MAX_CREDIT >= (1 << CREDIT_W) || STOCK_INIT < 1) begin : g_param_check
        $error("vending_machine_multi: illegal parameter set");
    end

    // Sums are formed one bit wider than credit, so an over-limit coin is
    // detected instead of wrapping.
    localparam logic [CREDIT_W:0]   c_MAX_CREDIT = (CREDIT_W+1)'(MAX_CREDIT);
    localparam logic [CREDIT_W-1:0] c_PRICE      = CREDIT_W'(PRICE);
    localparam logic [SEL_W:0]      c_N_ITEMS    = (SEL_W+1)'(N_ITEMS);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_CREDIT = 2'd1,
        S_VEND   = 2'd2,
        S_CHANGE = 2'd3
    } state_t;

    state_t              r_state, w_state_nxt;
    logic [CREDIT_W-1:0] r_credit, w_credit_nxt;
    logic [SEL_W-1:0]    r_vend_item, w_item_nxt;
    logic                r_vend, r_change, r_coin_rej, r_busy;
    logic                w_rej_nxt;

    logic [CREDIT_W:0]   w_coin_val;
    logic [CREDIT_W:0]   w_coin_sum;
    logic                w_coin_any;
    logic                w_coin_fits;
    logic                w_buy_ok;
    logic [CREDIT_W-1:0] w_remain;

    always_comb begin
        w_coin_val = '0;
        case (coin)
            2'b01:   w_coin_val = (CREDIT_W+1)'(1);
            2'b10:   w_coin_val = (CREDIT_W+1)'(2);
            2'b11:   w_coin_val = (CREDIT_W+1)'(5);
            default: w_coin_val = '0;
        endcase
    end

    assign w_coin_any  = (coin != 2'b00);
    assign w_coin_sum  = {1'b0, r_credit} + w_coin_val;
    assign w_coin_fits = (w_coin_sum <= c_MAX_CREDIT);
    // A buy is only considered with enough credit and an existing item.
    assign w_buy_ok    = buy && (r_credit >= c_PRICE) && ({1'b0, sel} < c_N_ITEMS);
    assign w_remain    = r_credit - c_PRICE;

`ifdef STOCK_COUNT_EN
    localparam int STOCK_W = $clog2(STOCK_INIT + 1);

    logic [STOCK_W-1:0] r_stock [N_ITEMS];
    logic               r_sold_out;
    logic               w_sold_nxt;
    logic               w_in_stock;

    assign w_in_stock = (r_stock[sel] != '0);

    // The counter of the dispensed item drops at the end of the VEND cycle.
    // A new buy cannot be evaluated before that, so no bypass is needed.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < N_ITEMS; i++) begin
                r_stock[i] <= STOCK_W'(STOCK_INIT);
            end
        end else begin
            for (int i = 0; i < N_ITEMS; i++) begin
                if (r_state == S_VEND && r_vend_item == SEL_W'(i) && r_stock[i] != '0) begin
                    r_stock[i] <= r_stock[i] - STOCK_W'(1);
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_sold_out <= 1'b0;
        end else begin
            r_sold_out <= w_sold_nxt;
        end
    end

    assign sold_out = r_sold_out;
`else
    assign sold_out = 1'b0;
`endif

    // Next-state and next-output logic.
    // In IDLE and CREDIT, cancel takes priority over buy, and buy over coin.
    always_comb begin
        w_state_nxt  = r_state;
        w_credit_nxt = r_credit;
        w_item_nxt   = '0;
        w_rej_nxt    = 1'b0;
`ifdef STOCK_COUNT_EN
        w_sold_nxt   = 1'b0;
`endif
        case (r_state)
            S_IDLE: begin
                if (w_coin_any) begin
                    if (w_coin_fits) begin
                        w_credit_nxt = w_coin_sum[CREDIT_W-1:0];
                        w_state_nxt  = S_CREDIT;
                    end else begin
                        w_rej_nxt = 1'b1;
                    end
                end
            end
            S_CREDIT: begin
                if (cancel) begin
                    w_state_nxt = S_CHANGE;
                    w_rej_nxt   = w_coin_any;
`ifdef STOCK_COUNT_EN
                end else if (w_buy_ok && !w_in_stock) begin
                    // A refused buy still counts as acted on, so a
                    // simultaneous coin is returned.
                    w_sold_nxt = 1'b1;
                    w_rej_nxt  = w_coin_any;
`endif
                end else if (w_buy_ok) begin
                    w_state_nxt = S_VEND;
                    w_item_nxt  = sel;
                    w_rej_nxt   = w_coin_any;
                end else if (w_coin_any) begin
                    if (w_coin_fits) begin
                        w_credit_nxt = w_coin_sum[CREDIT_W-1:0];
                    end else begin
                        w_rej_nxt = 1'b1;
                    end
                end
            end
            S_VEND: begin
                w_credit_nxt = w_remain;
                w_state_nxt  = (w_remain != '0) ? S_CHANGE : S_IDLE;
                w_rej_nxt    = w_coin_any;
            end
            S_CHANGE: begin
                // Leaving on the cycle the count reaches zero gives exactly
                // one pulse per unit of credit.
                if (r_credit != '0) begin
                    w_credit_nxt = r_credit - CREDIT_W'(1);
                end
                if (r_credit <= CREDIT_W'(1)) begin
                    w_state_nxt = S_IDLE;
                end
                w_rej_nxt = w_coin_any;
            end
            default: begin
                w_state_nxt  = S_IDLE;
                w_credit_nxt = '0;
            end
        endcase
    end

    // The state register and the registered outputs. The outputs are decoded
    // from the next state, so they line up with the state they describe.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state     <= S_IDLE;
            r_credit    <= '0;
            r_vend_item <= '0;
            r_vend      <= 1'b0;
            r_change    <= 1'b0;
            r_coin_rej  <= 1'b0;
            r_busy      <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_credit    <= w_credit_nxt;
            r_vend_item <= w_item_nxt;
            r_vend      <= (w_state_nxt == S_VEND);
            r_change    <= (w_state_nxt == S_CHANGE);
            r_coin_rej  <= w_rej_nxt;
            r_busy      <= (w_state_nxt == S_VEND) || (w_state_nxt == S_CHANGE);
        end
    end

    assign vend         = r_vend;
    assign vend_item    = r_vend_item;
    assign change_pulse = r_change;
    assign coin_rej     = r_coin_rej;
    assign credit       = r_credit;
    assign busy         = r_busy;

endmodule
`default_nettype wire

// File: tb/tb_vending_machine_multi.sv
`default_nettype none
// ============================================================================
//  Module      : tb_vending_machine_multi
//  Description : Table-driven bench for vending_machine_multi. Each record
//                holds the inputs of one cycle and the expected outputs after
//                that clock edge. Hand-written sequences cover the credit
//                ceiling, the long refund and the asynchronous reset. The
//                stock sequence is built only with STOCK_COUNT_EN.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_vending_machine_multi;

`ifdef STOCK_COUNT_EN
    localparam int c_STOCK_INIT = 1;
`else
    localparam int c_STOCK_INIT = 8;
`endif

    logic       clk;
    logic       rst;
    logic [1:0] coin;
    logic [1:0] sel;
    logic       buy;
    logic       cancel;
    logic       vend;
    logic [1:0] vend_item;
    logic       change_pulse;
    logic       coin_rej;
    logic [5:0] credit;
    logic       busy;
    logic       sold_out;

    vending_machine_multi #(
        .N_ITEMS    (4),
        .SEL_W      (2),
        .CREDIT_W   (6),
        .PRICE      (3),
        .MAX_CREDIT (63),
        .STOCK_INIT (c_STOCK_INIT)
    ) u_dut (
        .clk          (clk),
        .rst          (rst),
        .coin         (coin),
        .sel          (sel),
        .buy          (buy),
        .cancel       (cancel),
        .vend         (vend),
        .vend_item    (vend_item),
        .change_pulse (change_pulse),
        .coin_rej     (coin_rej),
        .credit       (credit),
        .busy         (busy),
        .sold_out     (sold_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [1:0] coin;
        logic [1:0] sel;
        logic       buy;
        logic       cancel;
        logic       e_vend;
        logic [1:0] e_item;
        logic       e_chg;
        logic       e_rej;
        logic [5:0] e_credit;
        logic       e_busy;
        logic       e_sold;
    } vec_t;

    int n_vec;
    int n_bad;
    vec_t vecs[$];

    function automatic vec_t mk(input logic [1:0] c, input logic [1:0] s, input logic b,
                                input logic x, input logic ev, input logic [1:0] ei,
                                input logic ec, input logic er, input logic [5:0] ecr,
                                input logic eb, input logic es);
        vec_t v;
        v.coin = c;  v.sel = s;  v.buy = b;  v.cancel = x;
        v.e_vend = ev; v.e_item = ei; v.e_chg = ec; v.e_rej = er;
        v.e_credit = ecr; v.e_busy = eb; v.e_sold = es;
        return v;
    endfunction

    task automatic check(input string nm, input vec_t e);
        n_vec++;
        if (vend !== e.e_vend || vend_item !== e.e_item || change_pulse !== e.e_chg ||
            coin_rej !== e.e_rej || credit !== e.e_credit || busy !== e.e_busy ||
            sold_out !== e.e_sold) begin
            n_bad++;
            $display("FAIL %s: got vend=%0b item=%0d chg=%0b rej=%0b credit=%0d busy=%0b sold=%0b, want vend=%0b item=%0d chg=%0b rej=%0b credit=%0d busy=%0b sold=%0b",
                     nm, vend, vend_item, change_pulse, coin_rej, credit, busy, sold_out,
                     e.e_vend, e.e_item, e.e_chg, e.e_rej, e.e_credit, e.e_busy, e.e_sold);
        end
    endtask

    // Drive one cycle of inputs, then sample just after the rising edge.
    task automatic step(input string nm, input vec_t v);
        coin   = v.coin;
        sel    = v.sel;
        buy    = v.buy;
        cancel = v.cancel;
        @(posedge clk);
        #1;
        check(nm, v);
    endtask

    initial begin
        n_vec  = 0;
        n_bad  = 0;
        rst    = 1'b0;
        coin   = 2'b00;
        sel    = 2'b00;
        buy    = 1'b0;
        cancel = 1'b0;

        //            coin  sel  buy cnc  vend item chg rej cred busy sold
        // Three 1-unit coins, then buy item 2 with exact credit.
        vecs.push_back(mk(2'b01, 2'd0, 0, 0,  0, 2'd0, 0, 0, 6'd1, 0, 0));
        vecs.push_back(mk(2'b01, 2'd0, 0, 0,  0, 2'd0, 0, 0, 6'd2, 0, 0));
        vecs.push_back(mk(2'b01, 2'd0, 0, 0,  0, 2'd0, 0, 0, 6'd3, 0, 0));
        vecs.push_back(mk(2'b00, 2'd2, 1, 0,  1, 2'd2, 0, 0, 6'd3, 1, 0));
        vecs.push_back(mk(2'b00, 2'd0, 0, 0,  0, 2'd0, 0, 0, 6'd0, 0, 0));
        // A 5-unit coin and a buy of item 0 leave two units of change.
        vecs.push_back(mk(2'b11, 2'd0, 0, 0,  0, 2'd0, 0, 0, 6'd5, 0, 0));
        vecs.push_back(mk(2'b00, 2'd0, 1, 0,  1, 2'd0, 0, 0, 6'd5, 1, 0));
        vecs.push_back(mk(2'b00, 2'd0, 0, 0,  0, 2'd0, 1, 0, 6'd2, 1, 0));
        vecs.push_back(mk(2'b00, 2'd0, 0, 0,  0, 2'd0, 1, 0, 6'd1, 1, 0));
        vecs.push_back(mk(2'b00, 2'd0, 0, 0,  0, 2'd0, 0, 0, 6'd0, 0, 0));
        // A 2-unit coin followed by cancel refunds two units.
        vecs.push_back(mk(2'b10, 2'd0, 0, 0,  0, 2'd0, 0, 0, 6'd2, 0, 0));
        vecs.push_back(mk(2'b00, 2'd0, 0, 1,  0, 2'd0, 1, 0, 6'd2, 1, 0));
        vecs.push_back(mk(2'b00, 2'd0, 0, 0,  0, 2'd0, 1, 0, 6'd1, 1, 0));
        vecs.push_back(mk(2'b00, 2'd0, 0, 0,  0, 2'd0, 0, 0, 6'd0, 0, 0));
        // Cancel in IDLE is ignored. Buy below the price is ignored.
        vecs.push_back(mk(2'b00, 2'd0, 0, 1,  0, 2'd0, 0, 0, 6'd0, 0, 0));
        vecs.push_back(mk(2'b01, 2'd0, 0, 0,  0, 2'd0, 0, 0, 6'd1, 0, 0));
        vecs.push_back(mk(2'b00, 2'd1, 1, 0,  0, 2'd0, 0, 0, 6'd1, 0, 0));
        vecs.push_back(mk(2'b10, 2'd0, 0, 0,  0, 2'd0, 0, 0, 6'd3, 0, 0));
        // A coin together with an accepted buy is rejected. A coin while in
        // VEND is rejected.
        vecs.push_back(mk(2'b01, 2'd3, 1, 0,  1, 2'd3, 0, 1, 6'd3, 1, 0));
        vecs.push_back(mk(2'b10, 2'd0, 0, 0,  0, 2'd0, 0, 1, 6'd0, 0, 0));
        vecs.push_back(mk(2'b00, 2'd0, 0, 0,  0, 2'd0, 0, 0, 6'd0, 0, 0));

        repeat (3) @(posedge clk);
        #1;
        check("reset_state", mk(2'b00, 2'd0, 0, 0, 0, 2'd0, 0, 0, 6'd0, 0, 0));
        rst = 1'b1;

        foreach (vecs[i]) begin
            step($sformatf("vec%0d", i), vecs[i]);
        end

        // Credit ceiling: fill to 62, then a 5-unit coin is refused and a
        // 1-unit coin reaches exactly 63.
        for (int k = 0; k < 12; k++) begin
            step("t4_fill", mk(2'b11, 2'd0, 0, 0, 0, 2'd0, 0, 0, 6'(5 * (k + 1)), 0, 0));
        end
        step("t4_to62",   mk(2'b10, 2'd0, 0, 0, 0, 2'd0, 0, 0, 6'd62, 0, 0));
        step("t4_rej5",   mk(2'b11, 2'd0, 0, 0, 0, 2'd0, 0, 1, 6'd62, 0, 0));
        step("t4_to63",   mk(2'b01, 2'd0, 0, 0, 0, 2'd0, 0, 0, 6'd63, 0, 0));
        step("t4_rej1",   mk(2'b01, 2'd0, 0, 0, 0, 2'd0, 0, 1, 6'd63, 0, 0));
        step("t4_cancel", mk(2'b00, 2'd0, 0, 1, 0, 2'd0, 1, 0, 6'd63, 1, 0));
        for (int k = 62; k >= 1; k--) begin
            step("t4_refund", mk(2'b00, 2'd0, 0, 0, 0, 2'd0, 1, 0, 6'(k), 1, 0));
        end
        step("t4_done",   mk(2'b00, 2'd0, 0, 0, 0, 2'd0, 0, 0, 6'd0, 0, 0));

        // Buy, cancel and coin in the same cycle: cancel wins and the coin is
        // rejected. Then reset is asserted in the middle of the refund.
        step("t5_credit", mk(2'b11, 2'd0, 0, 0, 0, 2'd0, 0, 0, 6'd5, 0, 0));
        step("t5_all",    mk(2'b01, 2'd1, 1, 1, 0, 2'd0, 1, 1, 6'd5, 1, 0));
        step("t5_pulse2", mk(2'b00, 2'd0, 0, 0, 0, 2'd0, 1, 0, 6'd4, 1, 0));
        #2;
        rst = 1'b0;
        #1;
        check("t5_async_rst", mk(2'b00, 2'd0, 0, 0, 0, 2'd0, 0, 0, 6'd0, 0, 0));
        @(posedge clk);
        #1;
        check("t5_held_rst", mk(2'b00, 2'd0, 0, 0, 0, 2'd0, 0, 0, 6'd0, 0, 0));
        rst = 1'b1;
        step("t5_fresh",  mk(2'b01, 2'd0, 0, 0, 0, 2'd0, 0, 0, 6'd1, 0, 0));
        step("t5_cancel", mk(2'b00, 2'd0, 0, 1, 0, 2'd0, 1, 0, 6'd1, 1, 0));
        step("t5_idle",   mk(2'b00, 2'd0, 0, 0, 0, 2'd0, 0, 0, 6'd0, 0, 0));

`ifdef STOCK_COUNT_EN
        // Stock of one: the first buy of item 0 vends, the second is refused.
        step("t6_c1",    mk(2'b01, 2'd0, 0, 0, 0, 2'd0, 0, 0, 6'd1, 0, 0));
        step("t6_c2",    mk(2'b01, 2'd0, 0, 0, 0, 2'd0, 0, 0, 6'd2, 0, 0));
        step("t6_c3",    mk(2'b01, 2'd0, 0, 0, 0, 2'd0, 0, 0, 6'd3, 0, 0));
        step("t6_buy1",  mk(2'b00, 2'd0, 1, 0, 1, 2'd0, 0, 0, 6'd3, 1, 0));
        step("t6_idle",  mk(2'b00, 2'd0, 0, 0, 0, 2'd0, 0, 0, 6'd0, 0, 0));
        step("t6_c5",    mk(2'b11, 2'd0, 0, 0, 0, 2'd0, 0, 0, 6'd5, 0, 0));
        step("t6_buy2",  mk(2'b00, 2'd0, 1, 0, 0, 2'd0, 0, 0, 6'd5, 0, 1));
        step("t6_keep",  mk(2'b00, 2'd0, 0, 0, 0, 2'd0, 0, 0, 6'd5, 0, 0));
        step("t6_cncl",  mk(2'b00, 2'd0, 0, 1, 0, 2'd0, 1, 0, 6'd5, 1, 0));
        for (int k = 4; k >= 1; k--) begin
            step("t6_refund", mk(2'b00, 2'd0, 0, 0, 0, 2'd0, 1, 0, 6'(k), 1, 0));
        end
        step("t6_done",  mk(2'b00, 2'd0, 0, 0, 0, 2'd0, 0, 0, 6'd0, 0, 0));
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
